// File: rtl/param_frame_pkg.sv
// Shared types and constants for the parameter frame loader.
// PARAM_READBACK_EN adds the READBACK state that echoes committed words to TX RAM.
package param_frame_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_HDR_CHK,
    S_STREAM,
    S_CHK,
    S_COMMIT,
`ifdef PARAM_READBACK_EN
    S_READBACK,
`endif
    S_ACK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_MAGIC = 2'd1,
    ERR_COUNT = 2'd2,
    ERR_CSUM  = 2'd3
  } err_t;

  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_COUNT_LSB = 8;
  localparam int HDR_SEQ_LSB   = 0;

  localparam logic [7:0] ACK_TAG = 8'hA5;

  function automatic logic [15:0] hdr_magic(input logic [31:0] w);
    return w[HDR_MAGIC_LSB +: 16];
  endfunction

  function automatic logic [7:0] hdr_count(input logic [31:0] w);
    return w[HDR_COUNT_LSB +: 8];
  endfunction

  function automatic logic [7:0] hdr_seq(input logic [31:0] w);
    return w[HDR_SEQ_LSB +: 8];
  endfunction

endpackage

// File: rtl/param_frame_loader_csum.sv
// 32-bit wrapping checksum accumulator with clear, seed and add, and an equality compare.
module param_csum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        seed,
  input  logic        add,
  input  logic [31:0] data,
  input  logic [31:0] compare,
  output logic        equal
);

  logic [31:0] sum_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sum_q <= '0;
    end else if (seed) begin
      sum_q <= data;
    end else if (add) begin
      sum_q <= sum_q + data;
    end
  end

  assign equal = (sum_q == compare);

endmodule

// File: rtl/param_frame_loader.sv
// Streams a parameter frame from RX RAM, validates header/checksum, commits atomically, acks via TX RAM.
// Optional PARAM_READBACK_EN echoes committed words to TX RAM addresses 1..count before the ack.
module param_frame_loader
  import param_frame_pkg::*;
#(
  parameter int                NUM_PARAMS = 16,
  parameter int                ADDR_W     = 11,
  parameter logic [15:0]       MAGIC      = 16'hEB08,
  parameter logic [ADDR_W-1:0] ACK_ADDR   = 11'h7FF
) (
  input  logic                     parameter_clk_clk,
  input  logic                     parameter_reset_reset_n,
  input  logic                     start_i,
  output logic [ADDR_W-1:0]        rx_address,
  output logic                     rx_chipselect,
  output logic                     rx_clken,
  output logic                     rx_write,
  output logic [3:0]               rx_byteenable,
  input  logic [31:0]              rx_readdata,
  output logic [ADDR_W-1:0]        tx_address,
  output logic                     tx_chipselect,
  output logic                     tx_clken,
  output logic                     tx_write,
  output logic [31:0]              tx_writedata,
  output logic [3:0]               tx_byteenable,
  output logic [NUM_PARAMS*32-1:0] params_o,
  output logic                     params_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [1:0]               err_o,
  output logic [15:0]              update_count_o
);

  state_t      state_q, state_d;
  logic        start_q;
  logic [7:0]  idx_q, count_q, seq_q, word_idx;
  err_t        err_q;
  logic        valid_q;
  logic [15:0] update_q;
  logic [31:0] shadow_q [NUM_PARAMS];
  logic [31:0] params_q [NUM_PARAMS];

  logic rise, magic_ok, count_ok, stream_last, add_en, csum_equal;
  logic [31:0] rb_data;

  assign rise        = start_i & ~start_q;
  assign magic_ok    = (hdr_magic(rx_readdata) == MAGIC);
  assign count_ok    = (hdr_count(rx_readdata) != 8'd0) &&
                       (hdr_count(rx_readdata) <= 8'(NUM_PARAMS));
  assign stream_last = (idx_q == count_q + 8'd1);
  // Data for address idx-1 returns while address idx is presented.
  assign add_en      = (state_q == S_STREAM) && (idx_q >= 8'd2);
  assign word_idx    = idx_q - 8'd2;

  param_csum_acc u_csum (
    .clk     (parameter_clk_clk),
    .rst_n   (parameter_reset_reset_n),
    .clear   (state_q == S_IDLE),
    .seed    (state_q == S_HDR_CHK),
    .add     (add_en),
    .data    (rx_readdata),
    .compare (rx_readdata),
    .equal   (csum_equal)
  );

`ifdef PARAM_READBACK_EN
  always_comb begin
    rb_data = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (idx_q == 8'(i + 1)) rb_data = params_q[i];
    end
  end
`else
  assign rb_data = '0;
`endif

  always_ff @(posedge parameter_clk_clk) begin
    if (!parameter_reset_reset_n) state_q <= S_IDLE;
    else                          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    state_d       = state_q;
    rx_chipselect = 1'b0;
    rx_address    = '0;
    tx_chipselect = 1'b0;
    tx_write      = 1'b0;
    tx_address    = '0;
    tx_writedata  = '0;
    done_o        = 1'b0;
    unique case (state_q)
      S_IDLE:    if (rise) state_d = S_HDR;
      S_HDR: begin
        rx_chipselect = 1'b1;
        state_d       = S_HDR_CHK;
      end
      S_HDR_CHK: state_d = (magic_ok && count_ok) ? S_STREAM : S_ACK;
      S_STREAM: begin
        rx_chipselect = 1'b1;
        rx_address    = ADDR_W'(idx_q);
        if (stream_last) state_d = S_CHK;
      end
      S_CHK:     state_d = csum_equal ? S_COMMIT : S_ACK;
`ifdef PARAM_READBACK_EN
      S_COMMIT:  state_d = S_READBACK;
      S_READBACK: begin
        tx_chipselect = 1'b1;
        tx_write      = 1'b1;
        tx_address    = ADDR_W'(idx_q);
        tx_writedata  = rb_data;
        if (idx_q == count_q) state_d = S_ACK;
      end
`else
      S_COMMIT:  state_d = S_ACK;
`endif
      S_ACK: begin
        tx_chipselect = 1'b1;
        tx_write      = 1'b1;
        tx_address    = ACK_ADDR;
        tx_writedata  = {ACK_TAG, 6'b0, err_q, seq_q, count_q};
        state_d       = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: the shadow and parameter arrays are register banks, not RAM, so they are reset like any flop.
  always_ff @(posedge parameter_clk_clk) begin
    if (!parameter_reset_reset_n) begin
      start_q  <= start_i;
      idx_q    <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      err_q    <= ERR_OK;
      valid_q  <= 1'b0;
      update_q <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        shadow_q[i] <= '0;
        params_q[i] <= '0;
      end
    end else begin
      start_q <= start_i;
      unique case (state_q)
        S_HDR_CHK: begin
          count_q <= hdr_count(rx_readdata);
          seq_q   <= hdr_seq(rx_readdata);
          idx_q   <= 8'd1;
          if (!magic_ok)      err_q <= ERR_MAGIC;
          else if (!count_ok) err_q <= ERR_COUNT;
        end
        S_STREAM: begin
          idx_q <= idx_q + 8'd1;
          for (int i = 0; i < NUM_PARAMS; i++) begin
            if (add_en && word_idx == 8'(i)) shadow_q[i] <= rx_readdata;
          end
        end
        S_CHK:     if (!csum_equal) err_q <= ERR_CSUM;
        S_COMMIT: begin
          for (int i = 0; i < NUM_PARAMS; i++) begin
            if (8'(i) < count_q) params_q[i] <= shadow_q[i];
          end
          valid_q  <= 1'b1;
          update_q <= update_q + 16'd1;
          err_q    <= ERR_OK;
          idx_q    <= 8'd1;
        end
`ifdef PARAM_READBACK_EN
        S_READBACK: idx_q <= idx_q + 8'd1;
`endif
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_flat
    assign params_o[32*g +: 32] = params_q[g];
  end

  assign rx_clken       = rx_chipselect;
  assign rx_write       = 1'b0;
  assign rx_byteenable  = 4'hF;
  assign tx_clken       = tx_chipselect;
  assign tx_byteenable  = 4'hF;
  assign params_valid_o = valid_q;
  assign busy_o         = (state_q != S_IDLE);
  assign err_o          = err_q;
  assign update_count_o = update_q;

endmodule

// File: tb/tb_param_frame_loader.sv
// Self-checking bench for param_frame_loader: RAM models plus a frame-rule reference model.
module tb_param_frame_loader;

  localparam int NP = 16;
  localparam int PW = NP * 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [10:0]   rx_address, tx_address;
  logic          rx_chipselect, rx_clken, rx_write;
  logic [3:0]    rx_byteenable, tx_byteenable;
  logic [31:0]   rx_readdata, tx_writedata;
  logic          tx_chipselect, tx_clken, tx_write;
  logic [PW-1:0] params_o;
  logic          params_valid_o, busy_o, done_o;
  logic [1:0]    err_o;
  logic [15:0]   update_count_o;

  param_frame_loader dut (
    .parameter_clk_clk       (clk),
    .parameter_reset_reset_n (rst_n),
    .start_i                 (start_i),
    .rx_address              (rx_address),
    .rx_chipselect           (rx_chipselect),
    .rx_clken                (rx_clken),
    .rx_write                (rx_write),
    .rx_byteenable           (rx_byteenable),
    .rx_readdata             (rx_readdata),
    .tx_address              (tx_address),
    .tx_chipselect           (tx_chipselect),
    .tx_clken                (tx_clken),
    .tx_write                (tx_write),
    .tx_writedata            (tx_writedata),
    .tx_byteenable           (tx_byteenable),
    .params_o                (params_o),
    .params_valid_o          (params_valid_o),
    .busy_o                  (busy_o),
    .done_o                  (done_o),
    .err_o                   (err_o),
    .update_count_o          (update_count_o)
  );

  always #5 clk = ~clk;

  logic [31:0] rx_mem [0:2047];
  logic [31:0] tx_mem [0:2047];
  int          rx_reads  = 0;
  int          tx_writes = 0;
  logic [10:0] last_tx_addr = '0;
  logic [31:0] last_tx_data = '0;

  always @(posedge clk) begin
    if (rx_chipselect && rx_clken) begin
      rx_readdata <= rx_mem[rx_address];
      rx_reads    <= rx_reads + 1;
    end
    if (tx_chipselect && tx_clken && tx_write) begin
      tx_mem[tx_address] <= tx_writedata;
      tx_writes          <= tx_writes + 1;
      last_tx_addr       <= tx_address;
      last_tx_data       <= tx_writedata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_params [NP];
  logic        m_valid;
  logic [15:0] m_upd;
  logic [1:0]  m_err;
  logic [31:0] exp_ack;
  int          exp_lat, exp_reads, exp_txw;
  bit          rb_on;

  function automatic logic [PW-1:0] model_flat();
    logic [PW-1:0] r;
    for (int i = 0; i < NP; i++) r[32*i +: 32] = m_params[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_params[i] = '0;
    m_valid = 1'b0;
    m_upd   = '0;
    m_err   = 2'd0;
  endtask

  // Places header, n payload words and checksum(+delta) into RX RAM.
  task automatic put_frame(input logic [31:0] hdr, input int n, input logic [31:0] delta,
                           input bit rnd);
    logic [31:0] s;
    rx_mem[0] = hdr;
    s = hdr;
    for (int k = 1; k <= n; k++) begin
      rx_mem[k] = rnd ? $urandom : 32'(k);
      s += rx_mem[k];
    end
    rx_mem[n+1] = s + delta;
  endtask

  // Applies the frame rules to whatever sits in RX RAM and predicts the outcome.
  task automatic model_frame();
    logic [31:0] hdr, s;
    int          cnt;
    hdr = rx_mem[0];
    cnt = int'(hdr[15:8]);
    exp_txw = 1;
    if (hdr[31:16] != 16'hEB08) begin
      m_err = 2'd1; exp_lat = 4; exp_reads = 1;
    end else if (cnt == 0 || cnt > NP) begin
      m_err = 2'd2; exp_lat = 4; exp_reads = 1;
    end else begin
      s = 32'd0;
      for (int k = 0; k <= cnt; k++) s += rx_mem[k];
      exp_reads = cnt + 2;
      if (s != rx_mem[cnt+1]) begin
        m_err = 2'd3; exp_lat = cnt + 6;
      end else begin
        m_err = 2'd0;
        exp_lat = cnt + 7 + (rb_on ? cnt : 0);
        exp_txw = 1 + (rb_on ? cnt : 0);
        for (int i = 0; i < cnt; i++) m_params[i] = rx_mem[i+1];
        m_valid = 1'b1;
        m_upd   = m_upd + 16'd1;
      end
    end
    exp_ack = {8'hA5, 6'b0, m_err, hdr[7:0], hdr[15:8]};
  endtask

  task automatic run_frame(input string tag);
    int r0, w0, cyc;
    bit seen;
    model_frame();
    r0 = rx_reads;
    w0 = tx_writes;
    @(negedge clk);
    start_i = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    check({tag, ".done_seen"}, PW'(seen), PW'(1));
    check({tag, ".latency"}, PW'(cyc), PW'(exp_lat));
    check({tag, ".err"}, PW'(err_o), PW'(m_err));
    check({tag, ".params"}, params_o, model_flat());
    check({tag, ".valid"}, PW'(params_valid_o), PW'(m_valid));
    check({tag, ".upd"}, PW'(update_count_o), PW'(m_upd));
    check({tag, ".ack_addr"}, PW'(last_tx_addr), PW'(11'h7FF));
    check({tag, ".ack_data"}, PW'(last_tx_data), PW'(exp_ack));
    check({tag, ".rx_reads"}, PW'(rx_reads - r0), PW'(exp_reads));
    check({tag, ".tx_writes"}, PW'(tx_writes - w0), PW'(exp_txw));
    @(posedge clk);
    @(negedge clk);
    check({tag, ".busy_clear"}, PW'(busy_o), PW'(0));
  endtask

  initial begin
    int dones, w0, cnt;
`ifdef PARAM_READBACK_EN
    rb_on = 1'b1;
`else
    rb_on = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) begin
      rx_mem[i] = '0;
      tx_mem[i] = '0;
    end
    model_reset();
    rst_n   = 1'b0;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", PW'(busy_o), PW'(0));
    check("rst.done", PW'(done_o), PW'(0));
    check("rst.err", PW'(err_o), PW'(0));
    check("rst.params", params_o, '0);
    check("rst.valid", PW'(params_valid_o), PW'(0));
    check("rst.upd", PW'(update_count_o), PW'(0));
    check("rst.tx_write", PW'(tx_write), PW'(0));
    check("rst.rx_write", PW'(rx_write), PW'(0));
    check("rst.rx_cs", PW'(rx_chipselect), PW'(0));
    check("rst.byteen", PW'({rx_byteenable, tx_byteenable}), PW'(8'hFF));
    rst_n = 1'b1;
    @(negedge clk);

    put_frame(32'hEB08_1003, 16, 32'd0, 1'b0);
    run_frame("good16");
    check("good16.word0", PW'(params_o[31:0]), PW'(1));
    check("good16.word15", PW'(params_o[511:480]), PW'(16));
    check("good16.ack_const", PW'(last_tx_data), PW'(32'hA500_0310));

    put_frame(32'hEB09_1003, 16, 32'd0, 1'b1);
    run_frame("bad_magic");
    check("bad_magic.ack_const", PW'(last_tx_data), PW'(32'hA501_0310));

    put_frame(32'hEB08_1105, 17, 32'd0, 1'b1);
    run_frame("bad_count17");
    put_frame(32'hEB08_0007, 0, 32'd0, 1'b1);
    run_frame("bad_count0");
    put_frame(32'hEB08_0A22, 10, 32'd1, 1'b1);
    run_frame("bad_csum");

    for (int t = 0; t < 6; t++) begin
      cnt = $urandom_range(1, NP);
      put_frame({16'hEB08, 8'(cnt), 8'($urandom)}, cnt,
                ($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0, 1'b1);
      run_frame("random");
    end

`ifdef PARAM_READBACK_EN
    put_frame(32'hEB08_0444, 4, 32'd0, 1'b1);
    run_frame("readback4");
    for (int k = 1; k <= 4; k++) check("readback4.word", PW'(tx_mem[k]), PW'(m_params[k-1]));
`endif

    // Second trigger edge during a load must be ignored.
    put_frame(32'hEB08_0811, 8, 32'd0, 1'b1);
    model_frame();
    @(negedge clk);
    start_i = 1'b1;
    dones = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) dones++;
      if (c == 3) start_i = 1'b0;
      if (c == 5) start_i = 1'b1;
    end
    check("retrigger.dones", PW'(dones), PW'(1));
    check("retrigger.params", params_o, model_flat());
    start_i = 1'b0;
    @(negedge clk);

    // Reset during STREAM aborts with no ack; a held-high start must not retrigger.
    put_frame(32'hEB08_1055, 16, 32'd0, 1'b1);
    w0 = tx_writes;
    start_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("abort.busy", PW'(busy_o), PW'(0));
    check("abort.params", params_o, model_flat());
    check("abort.valid", PW'(params_valid_o), PW'(0));
    check("abort.upd", PW'(update_count_o), PW'(0));
    check("abort.rx_cs", PW'(rx_chipselect), PW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort.no_retrigger", PW'(busy_o), PW'(0));
    check("abort.no_txwrite", PW'(tx_writes - w0), PW'(0));
    start_i = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_frame_loader.md
Name: param_frame_loader

Overview:
- Consumer of the parameter RX RAM's second port (s2) in the parameter clock domain.
- On a trigger from the loop GPIO output, it streams a parameter frame out of RX RAM and checks its header and checksum.
- A valid frame is committed atomically to a flat parameter bus that drives the observer/controller datapath.
- A status/acknowledge word is always written back through the TX RAM s2 port.

Parameters:
- NUM_PARAMS, 16, maximum parameter words per frame (1..254).
- ADDR_W, 11, RAM s2 word-address width.
- MAGIC, 16'hEB08, required value in header bits [31:16].
- ACK_ADDR, 11'h7FF, TX RAM word address that receives the ack word.

Ports:
- parameter_clk_clk, in, 1, sole clock.
- parameter_reset_reset_n, in, 1, synchronous active-low reset.
- start_i, in, 1, trigger level from loop GPIO out port; rising edge starts a load.
- rx_address, out, ADDR_W, RX RAM s2 address.
- rx_chipselect, out, 1, RX RAM s2 chipselect.
- rx_clken, out, 1, RX RAM s2 clock enable.
- rx_write, out, 1, always 0.
- rx_byteenable, out, 4, always 4'hF.
- rx_readdata, in, 32, RX RAM s2 read data (read latency 1).
- tx_address, out, ADDR_W, TX RAM s2 address.
- tx_chipselect, out, 1, TX RAM s2 chipselect.
- tx_clken, out, 1, TX RAM s2 clock enable.
- tx_write, out, 1, TX RAM s2 write strobe.
- tx_writedata, out, 32, TX RAM s2 write data.
- tx_byteenable, out, 4, always 4'hF.
- params_o, out, NUM_PARAMS*32, committed parameters; word i occupies bits [32i+31:32i].
- params_valid_o, out, 1, at least one frame has been committed since reset.
- busy_o, out, 1, high from trigger until the ack write completes.
- done_o, out, 1, one-cycle pulse when the ack is written.
- err_o, out, 2, status of the last frame (0 OK, 1 bad magic, 2 bad count, 3 checksum).
- update_count_o, out, 16, number of successful commits; wraps at 16 bits.

Behaviour:
- Reset (synchronous, parameter_reset_reset_n=0 at clock edge):
  - All outputs 0; params_o, the shadow registers and update_count_o cleared; FSM to IDLE.
  - start_i edge detector preloaded to the current start_i, so a level that is already high does not trigger.
- Reset mid-operation aborts immediately. No ack is written and no partial commit occurs.
- RAM timing:
  - chipselect and clken asserted only in cycles that present an address.
  - RX data for the address driven in cycle t is sampled in cycle t+1.
- FSM states and transitions:
  - IDLE: on a start_i rising edge, set busy_o=1 and go to HDR.
  - HDR: drive rx_address=0 and go to HDR_CHK.
  - HDR_CHK: sample the header.
    - Fields: magic=[31:16], count=[15:8], seq=[7:0].
    - magic≠MAGIC → err 1 → ACK.
    - count==0 or count>NUM_PARAMS → err 2 → ACK.
    - Otherwise seed the checksum with the header and go to STREAM.
  - STREAM: issue addresses 1..count+1 on consecutive cycles, one per cycle, no bubbles.
    - Each returning word k (k≤count) goes to shadow[k-1] and is added to the checksum.
    - Word count+1 is the expected checksum.
  - CHK: compare the 32-bit wrapping sum of words 0..count with the checksum word.
    - Equal → COMMIT.
    - Not equal → err 3 → ACK.
  - COMMIT: in one cycle, load params_o words 0..count-1 from the shadow registers.
    - Words count..NUM_PARAMS-1 are held unchanged.
    - Set params_valid_o=1, increment update_count_o, err=0.
  - ACK: write {8'hA5, 6'b0, err[1:0], seq[7:0], count[7:0]} to ACK_ADDR.
    - tx_write is high for exactly one cycle.
    - seq and count are taken from the header even on error.
  - DONE: pulse done_o, clear busy_o, return to IDLE.
- On any error, params_o, params_valid_o and update_count_o are unchanged.
- start_i edges while busy_o=1 are ignored and not queued.
- Latency, trigger edge to done_o pulse, for a good frame: count+7 cycles (NUM_PARAMS=16, count=16 → 23).

Optional Feature:
- Macro: PARAM_READBACK_EN.
- Defined: after a successful COMMIT, and before ACK, a READBACK state writes the committed words to TX RAM addresses 1..count, one per cycle.
  - Latency increases by count cycles.
- Not defined: only the ack word is written to TX RAM; the READBACK state is absent.

Decomposition:
- Package param_frame_pkg holds:
  - the FSM state enum;
  - status codes ERR_OK, ERR_MAGIC, ERR_COUNT, ERR_CSUM;
  - header field bit positions;
  - the ack tag 8'hA5.
- One sub-module, param_csum_acc: a 32-bit wrapping accumulator with clear, seed and add, plus an equality output.

Test Plan:
- Good frame, count=16: header 32'hEB08_1003, params 1..16, correct checksum → params_o word 0=1 and word 15=16; update_count_o=1; ack word 32'hA500_0310; done_o at cycle 23.
- Bad magic: header 32'hEB09_1003 → err_o=1, params_o unchanged, ack 32'hA501_0310, no STREAM reads.
- Bad count: header count=17 → err_o=2. Header count=0 → err_o=2. In both cases params_valid_o remains at its prior value.
- Checksum wrong by +1 → err_o=3, previous parameters retained, update_count_o not incremented.
- Second start_i edge at cycle 5 of a load → ignored, exactly one done_o. Reset asserted during STREAM → no tx_write, all outputs 0 on the next cycle.
- With PARAM_READBACK_EN, count=4 → TX RAM addresses 1..4 receive the committed words and the ack follows; done_o at cycle 15.
